approx_wallace_mac_accumulator: RTL and testbench

//  Consumer end of the approximate 8-bit Wallace tree: a streaming multiply-accumulate

---
 rtl/approx_wallace_mac_accumulator.sv | 157 +++++++++++++++
 tb/tb_approx_wallace_mac_accumulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_wallace_mac_accumulator.sv
// Streaming multiply-accumulate built around an approximate 8x8 Wallace-tree multiplier.
// Operand pairs arrive over valid/ready; each vector's dot product leaves over valid/ready.

module approx_eight_bit_wallace_tree (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // Columns 0..3 are approximated: each output bit is the OR of its partial
    // products and generates no carry. Columns 4..15 go through an exact 3:2 tree.
    localparam logic [15:0] UPPER_MASK = 16'hFFF0;

    logic [15:0] row [8];
    logic [3:0]  low_bits;
    logic [15:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;

    function automatic logic [15:0] fa_sum(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] fa_carry(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // NOTE: always_comb assigns every output before any conditional use, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row[i] = ({8'b0, a & {8{b[i]}}} << i) & UPPER_MASK;
        end
        low_bits = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i <= c; i++) begin
                low_bits[c] = low_bits[c] | (a[i] & b[c-i]);
            end
        end
        // Wallace reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
        s1 = fa_sum(row[0], row[1], row[2]);  c1 = fa_carry(row[0], row[1], row[2]);
        s2 = fa_sum(row[3], row[4], row[5]);  c2 = fa_carry(row[3], row[4], row[5]);
        s3 = fa_sum(s1, c1, s2);              c3 = fa_carry(s1, c1, s2);
        s4 = fa_sum(c2, row[6], row[7]);      c4 = fa_carry(c2, row[6], row[7]);
        s5 = fa_sum(s3, c3, s4);              c5 = fa_carry(s3, c3, s4);
        s6 = fa_sum(s5, c5, c4);              c6 = fa_carry(s5, c5, c4);
        p  = (s6 + c6) | {12'b0, low_bits};
    end
endmodule

module approx_wallace_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic               p_valid_q, p_valid_d;
    logic [15:0]        p_prod_q, p_prod_d;
    logic               p_last_q, p_last_d;
    logic               p_first_q, p_first_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               fin_q, fin_d;

    logic [15:0]        mult_p;
    logic               accept;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W:0]     acc_sum;

    approx_eight_bit_wallace_tree u_mult (
        .a (in_a),
        .b (in_b),
        .p (mult_p)
    );

    assign in_ready  = !rst && (state_q == IDLE || state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        // Product stage loads only on a handshake, so idle operand values never reach state.
        p_valid_d = accept;
        p_prod_d  = accept ? mult_p : p_prod_q;
        p_last_d  = accept && in_last;
        p_first_d = accept && (state_q == IDLE);

        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        fin_d    = p_valid_q && p_last_q;
        acc_base = p_first_q ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, p_prod_q};
        if (p_valid_q) begin
            acc_d = acc_sum[ACC_W-1:0];
            if (p_first_q) begin
                count_d = CNT_ONE;
                ovf_d   = acc_sum[ACC_W];
            end else begin
                count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
                ovf_d   = ovf_q | acc_sum[ACC_W] | (count_q == CNT_MAX);
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (fin_q) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_valid_q <= 1'b0;
            p_prod_q  <= '0;
            p_last_q  <= 1'b0;
            p_first_q <= 1'b0;
            acc_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_valid_q <= p_valid_d;
            p_prod_q  <= p_prod_d;
            p_last_q  <= p_last_d;
            p_first_q <= p_first_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            fin_q     <= fin_d;
        end
    end
endmodule

// File: tb/tb_approx_wallace_mac_accumulator.sv
// Randomised bench for the approximate Wallace MAC; two instances (24- and 16-bit accumulators)
// share one input stream and are checked against a column-level model of the multiplier.

module tb_approx_wallace_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy24, ov24, ovf24, rdy16, ov16, ovf16;
    logic [23:0] acc24;
    logic [15:0] acc16;
    logic [7:0]  cnt24, cnt16;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    approx_wallace_mac_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24),
        .out_count(cnt24), .out_ovf(ovf24)
    );

    approx_wallace_mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
        .out_count(cnt16), .out_ovf(ovf16)
    );

    // Column view: columns below 4 contribute a single OR'd bit, higher columns the exact count.
    function automatic longint approx_mul(input int a, input int b);
        longint r = 0;
        for (int c = 0; c < 16; c++) begin
            int n = 0;
            for (int i = 0; i < 8; i++) begin
                int j = c - i;
                if (j >= 0 && j < 8 && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) n++;
            end
            if (c < 4) r += (n != 0) ? (longint'(1) << c) : 0;
            else       r += longint'(n) << c;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns once it has been taken; stalls counts cycles waited.
    task automatic send(input int a, input int b, input bit last, output int stalls);
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_last  = last;
        stalls   = 0;
        while (rdy24 !== 1'b1 && stalls < 50) begin
            step();
            stalls++;
        end
        if (rdy24 !== 1'b1) begin
            chk_cnt++;
            $display("FAIL send_timeout in_ready=%b want 1", rdy24);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
    endtask

    task automatic check_result(input string name, input longint sum, input int n);
        int          waited = 0;
        logic [23:0] e_acc24 = 24'(sum);
        logic [15:0] e_acc16 = 16'(sum);
        logic [7:0]  e_cnt   = (n > 255) ? 8'd255 : 8'(n);
        logic        e_ovf24 = (n > 255) || (sum >= (longint'(1) << 24));
        logic        e_ovf16 = (n > 255) || (sum >= (longint'(1) << 16));
        while (ov24 !== 1'b1 && waited < 400) begin
            step();
            waited++;
        end
        chk_cnt++;
        if (ov24 !== 1'b1 || ov16 !== 1'b1)
            $display("FAIL %s out_valid got %b/%b want 1/1", name, ov24, ov16);
        else pass_cnt++;
        chk_cnt++;
        if (acc24 !== e_acc24 || cnt24 !== e_cnt || ovf24 !== e_ovf24)
            $display("FAIL %s acc24 got acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d ovf=%b",
                     name, acc24, cnt24, ovf24, e_acc24, e_cnt, e_ovf24);
        else pass_cnt++;
        chk_cnt++;
        if (acc16 !== e_acc16 || cnt16 !== e_cnt || ovf16 !== e_ovf16)
            $display("FAIL %s acc16 got acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d ovf=%b",
                     name, acc16, cnt16, ovf16, e_acc16, e_cnt, e_ovf16);
        else pass_cnt++;
        if (out_ready === 1'b1) begin
            step();
            chk_cnt++;
            if (ov24 !== 1'b0 || rdy24 !== 1'b1)
                $display("FAIL %s handshake got out_valid=%b in_ready=%b want 0/1",
                         name, ov24, rdy24);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        repeat (3) begin
            step();
            if (rdy24 !== 1'b0 || rdy16 !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_in_ready got %0d high cycles want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (ov24 !== 1'b0 || acc24 !== 24'd0 || cnt24 !== 8'd0 || ovf24 !== 1'b0)
            $display("FAIL reset_outputs got v=%b acc=%0d cnt=%0d ovf=%b want 0/0/0/0",
                     ov24, acc24, cnt24, ovf24);
        else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++;
        if (rdy24 !== 1'b1) $display("FAIL reset_release in_ready got %b want 1", rdy24);
        else pass_cnt++;
    endtask

    task automatic test_single_beat();
        int st;
        send(0, 200, 1'b1, st);
        step();
        chk_cnt++;
        if (ov24 !== 1'b0) $display("FAIL single_latency_t1 out_valid got %b want 0", ov24);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (ov24 !== 1'b1) $display("FAIL single_latency_t2 out_valid got %b want 1", ov24);
        else pass_cnt++;
        check_result("single_beat", approx_mul(0, 200), 1);
    endtask

    task automatic test_back_to_back();
        int     va[4] = '{3, 10, 255, 7};
        int     vb[4] = '{5, 10, 255, 0};
        int     st, total_stall = 0, busy_bad = 0, guard = 0;
        longint sum = 0;
        for (int k = 0; k < 4; k++) begin
            send(va[k], vb[k], k == 3, st);
            total_stall += st;
            sum += approx_mul(va[k], vb[k]);
        end
        chk_cnt++;
        if (total_stall != 0) $display("FAIL b2b_stalls got %0d want 0", total_stall);
        else pass_cnt++;
        while (ov24 !== 1'b1 && guard < 20) begin
            if (rdy24 !== 1'b0) busy_bad++;
            step();
            guard++;
        end
        if (rdy24 !== 1'b0) busy_bad++;
        chk_cnt++;
        if (busy_bad != 0) $display("FAIL b2b_in_ready_drain got %0d high cycles want 0", busy_bad);
        else pass_cnt++;
        check_result("back_to_back", sum, 4);
    endtask

    task automatic test_backpressure();
        int          st, bad = 0;
        longint      sum;
        logic [23:0] e_acc;
        int          a0 = $urandom_range(0, 255), b0 = $urandom_range(0, 255);
        int          a1 = $urandom_range(0, 255), b1 = $urandom_range(0, 255);
        sum   = approx_mul(a0, b0) + approx_mul(a1, b1);
        e_acc = 24'(sum);
        out_ready = 1'b0;
        send(a0, b0, 1'b0, st);
        send(a1, b1, 1'b1, st);
        repeat (3) step();
        repeat (10) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            in_last  = 1'b0;
            step();
            if (rdy24 !== 1'b0 || ov24 !== 1'b1 || acc24 !== e_acc || cnt24 !== 8'd2) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL backpressure_hold got %0d bad cycles want 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        check_result("backpressure", sum, 2);
        send(5, 6, 1'b1, st);
        check_result("after_backpressure", approx_mul(5, 6), 1);
    endtask

    task automatic test_overflow();
        int     st;
        longint sum = 0;
        for (int k = 0; k < 300; k++) begin
            send(255, 255, k == 299, st);
            sum += approx_mul(255, 255);
        end
        check_result("overflow_300", sum, 300);
        // Two full-scale products overflow 16 bits through the carry path only.
        send(255, 255, 1'b0, st);
        send(255, 255, 1'b1, st);
        check_result("acc_carry", 2 * approx_mul(255, 255), 2);
    endtask

    task automatic test_random_vectors();
        for (int v = 0; v < 8; v++) begin
            int     len = $urandom_range(1, 6);
            int     st;
            longint sum = 0;
            for (int k = 0; k < len; k++) begin
                int a = $urandom_range(0, 255);
                int b = $urandom_range(0, 255);
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_a     = 'x;
                    in_b     = 'x;
                    repeat ($urandom_range(1, 3)) step();
                end
                sum += approx_mul(a, b);
                send(a, b, k == len - 1, st);
            end
            check_result($sformatf("random_vec%0d", v), sum, len);
        end
    endtask

    task automatic test_reset_mid_vector();
        int st, bad = 0;
        send(200, 100, 1'b0, st);
        send(50, 60, 1'b0, st);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (4) begin
            step();
            if (ov24 !== 1'b0 || cnt24 !== 8'd0 || acc24 !== 24'd0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_mid_clear got %0d bad cycles want 0", bad);
        else pass_cnt++;
        send(2, 3, 1'b1, st);
        check_result("reset_mid_vector", approx_mul(2, 3), 1);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_random_vectors();
        test_reset_mid_vector();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached want finish");
        $fatal(1);
    end
endmodule
